branch_target_buffer: RTL

- Direct-mapped, tagged branch target buffer with two lookup ports and two update ports, one per superscalar way.
- Sits beside the local-history direction predictor in the fetch stage and feeds the IF next-PC mux.
  - The predictor supplies taken/not-taken; this block supplies the target address and whether one is known.
- Resolved branches from execute/commit write targets back, mirroring the predictor's update ports.

---
 rtl/btb_pkg.sv | 25 ++
 rtl/branch_target_buffer.sv | 96 +++++++++
 2 files changed

// File: rtl/btb_pkg.sv
// Shared BTB geometry, entry layout and PC-to-index/tag helpers.
// The direction predictor uses the same helpers for its indexing.
package btb_pkg;

    localparam int unsigned BTB_SIZE = 32;
    localparam int unsigned TAG_W    = 10;
    localparam int unsigned IDX_W    = $clog2(BTB_SIZE);
    localparam int unsigned PC_W     = 64;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [PC_W-1:0]   target;
    } btb_entry_t;

    // Bits [1:0] are ignored: instructions are word aligned.
    function automatic logic [IDX_W-1:0] btb_index(input logic [PC_W-1:0] pc);
        return pc[IDX_W+1:2];
    endfunction

    function automatic logic [TAG_W-1:0] btb_tag(input logic [PC_W-1:0] pc);
        return pc[IDX_W+TAG_W+1:IDX_W+2];
    endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped tagged BTB: two combinational lookup ports, two update ports.
// Port 2 is younger, so it wins same-index updates; flush beats any update.
module branch_target_buffer
    import btb_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] if_inst1_pc,
    input  logic        inst1_valid,
    input  logic [63:0] if_inst2_pc,
    input  logic        inst2_valid,
    input  logic [63:0] branch_pc1,
    input  logic [63:0] branch_target1,
    input  logic        branch_result1,
    input  logic        branch_valid1,
    input  logic [63:0] branch_pc2,
    input  logic [63:0] branch_target2,
    input  logic        branch_result2,
    input  logic        branch_valid2,
    input  logic        btb_flush,
    output logic        inst1_btb_hit,
    output logic [63:0] inst1_btb_target,
    output logic        inst2_btb_hit,
    output logic [63:0] inst2_btb_target
);

    btb_entry_t entries_q [BTB_SIZE];
    btb_entry_t entries_d [BTB_SIZE];

    logic [IDX_W-1:0] rd_idx1, rd_idx2, wr_idx1, wr_idx2;
    btb_entry_t       rd_entry1, rd_entry2;
    logic             wr_en1, wr_en2;

    assign rd_idx1 = btb_index(if_inst1_pc);
    assign rd_idx2 = btb_index(if_inst2_pc);
    assign wr_idx1 = btb_index(branch_pc1);
    assign wr_idx2 = btb_index(branch_pc2);

    // Not-taken resolutions leave the entry alone; direction is not stored here.
    assign wr_en1 = branch_valid1 && branch_result1;
    assign wr_en2 = branch_valid2 && branch_result2;

    always_comb begin
        for (int i = 0; i < BTB_SIZE; i++) begin
            entries_d[i] = entries_q[i];
        end
        if (btb_flush) begin
            for (int i = 0; i < BTB_SIZE; i++) begin
                entries_d[i].valid = 1'b0;
            end
        end else begin
            if (wr_en1) begin
                entries_d[wr_idx1].valid  = 1'b1;
                entries_d[wr_idx1].tag    = btb_tag(branch_pc1);
                entries_d[wr_idx1].target = branch_target1;
            end
            // Applied last so a same-index port-1 write is fully overwritten.
            if (wr_en2) begin
                entries_d[wr_idx2].valid  = 1'b1;
                entries_d[wr_idx2].tag    = btb_tag(branch_pc2);
                entries_d[wr_idx2].target = branch_target2;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BTB_SIZE; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < BTB_SIZE; i++) begin
                entries_q[i] <= entries_d[i];
            end
        end
    end

    // Reads see registered state only, so same-cycle updates are not bypassed.
    always_comb begin
        rd_entry1        = entries_q[rd_idx1];
        rd_entry2        = entries_q[rd_idx2];
        inst1_btb_hit    = inst1_valid && rd_entry1.valid
                           && (rd_entry1.tag == btb_tag(if_inst1_pc));
        inst2_btb_hit    = inst2_valid && rd_entry2.valid
                           && (rd_entry2.tag == btb_tag(if_inst2_pc));
        inst1_btb_target = inst1_btb_hit ? rd_entry1.target : '0;
        inst2_btb_target = inst2_btb_hit ? rd_entry2.target : '0;
    end

    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_inst1_pc[63:IDX_W+TAG_W+2], if_inst1_pc[1:0],
                              if_inst2_pc[63:IDX_W+TAG_W+2], if_inst2_pc[1:0],
                              branch_pc1[63:IDX_W+TAG_W+2], branch_pc1[1:0],
                              branch_pc2[63:IDX_W+TAG_W+2], branch_pc2[1:0]};

endmodule
